// File: rtl/add_sub_pkg.sv
// Shared mode encodings for the add_sub block.
// Decode is {S1, S2}.
package add_sub_pkg;

  localparam logic [1:0] MODE_ADD    = 2'b00;
  localparam logic [1:0] MODE_SUB_LS = 2'b10;
  localparam logic [1:0] MODE_SUB_SL = 2'b01;
  localparam logic [1:0] MODE_HOLD   = 2'b11;

  // True when the mode asks the result register to load a new value.
  function automatic logic mode_loads(logic [1:0] mode);
    return (mode == MODE_ADD) || (mode == MODE_SUB_LS) || (mode == MODE_SUB_SL);
  endfunction

endpackage

// File: rtl/add_sub_core.sv
// Combinational add/subtract datapath for add_sub.
// Operands are zero-extended by one bit, so sums keep their carry and differences wrap mod 2^(WIDTH+1).
module add_sub_core
  import add_sub_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] l_op,
  input  logic [WIDTH-1:0] s_op,
  output logic [WIDTH:0]   result,
  output logic             load
);

  logic [WIDTH:0] l_ext;
  logic [WIDTH:0] s_ext;

  assign l_ext = {1'b0, l_op};
  assign s_ext = {1'b0, s_op};

  always_comb begin
    result = '0;
    load   = mode_loads(mode);
    case (mode)
      MODE_ADD:    result = l_ext + s_ext;
      MODE_SUB_LS: result = l_ext - s_ext;
      MODE_SUB_SL: result = s_ext - l_ext;
      default:     result = '0;
    endcase
  end

endmodule

// File: rtl/add_sub.sv
// Registered add/subtract unit: dout = L+S, L-S, S-L or hold, selected by {S1,S2}.
// Defining ADD_SUB_PIPE_EN adds a resettable input register stage (2-cycle latency).
module add_sub
  import add_sub_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             S1,
  input  logic             S2,
  input  logic [WIDTH-1:0] mat_L,
  input  logic [WIDTH-1:0] mat_S,
  output logic [WIDTH:0]   dout
);

  logic [1:0]       mode;
  logic [WIDTH-1:0] l_op;
  logic [WIDTH-1:0] s_op;
  logic [WIDTH:0]   result;
  logic             load;

`ifdef ADD_SUB_PIPE_EN
  logic [1:0]       mode_q;
  logic [WIDTH-1:0] l_q;
  logic [WIDTH-1:0] s_q;

  // Cleared stage decodes as 0 + 0, so dout stays 0 for the cycle after reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      mode_q <= '0;
      l_q    <= '0;
      s_q    <= '0;
    end else begin
      mode_q <= {S1, S2};
      l_q    <= mat_L;
      s_q    <= mat_S;
    end
  end

  assign mode = mode_q;
  assign l_op = l_q;
  assign s_op = s_q;
`else
  assign mode = {S1, S2};
  assign l_op = mat_L;
  assign s_op = mat_S;
`endif

  add_sub_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .mode   (mode),
    .l_op   (l_op),
    .s_op   (s_op),
    .result (result),
    .load   (load)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      dout <= '0;
    end else if (load) begin
      dout <= result;
    end
  end

endmodule

// File: tb/tb_add_sub.sv
// Self-checking bench for add_sub (WIDTH=4, single-cycle build).
module tb_add_sub;

  localparam int W   = 4;
  localparam int MOD = 1 << (W + 1);

  logic         CLK;
  logic         RST;
  logic         S1;
  logic         S2;
  logic [W-1:0] mat_L;
  logic [W-1:0] mat_S;
  logic [W:0]   dout;

  int passed;
  int total;
  int exp_dout;

  add_sub #(
    .WIDTH (W)
  ) dut (
    .CLK   (CLK),
    .RST   (RST),
    .S1    (S1),
    .S2    (S2),
    .mat_L (mat_L),
    .mat_S (mat_S),
    .dout  (dout)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Reference: plain modular arithmetic on integer operand values.
  function automatic int model_next(bit rst, bit s1, bit s2, int l, int s, int prev);
    if (rst) return 0;
    if (!s1 && !s2) return (l + s) % MOD;
    if (s1 && !s2) return (l - s + MOD) % MOD;
    if (!s1 && s2) return (s - l + MOD) % MOD;
    return prev;
  endfunction

  // Apply one cycle of inputs at negedge, let the edge happen, then advance the model.
  task automatic step(input bit rst_v, input bit s1_v, input bit s2_v, input int l_v,
                      input int s_v);
    @(negedge CLK);
    RST   = rst_v;
    S1    = s1_v;
    S2    = s2_v;
    mat_L = W'(l_v);
    mat_S = W'(s_v);
    @(posedge CLK);
    #1;
    exp_dout = model_next(rst_v, s1_v, s2_v, l_v, s_v, exp_dout);
  endtask

  task automatic test_reset();
    step(1'b1, 1'($urandom), 1'($urandom), int'($urandom_range(0, 15)),
         int'($urandom_range(0, 15)));
    total++;
    if (dout !== 5'd0) $display("FAIL reset: dout=%b expected=%b", dout, 5'd0);
    else passed++;
  endtask

  task automatic test_add();
    step(1'b0, 1'b0, 1'b0, 1, 3);
    total++;
    if (dout !== 5'd4) $display("FAIL add_1_3: dout=%b expected=%b", dout, 5'd4);
    else passed++;
    step(1'b0, 1'b0, 1'b0, 8, 8);
    total++;
    if (dout !== 5'd16) $display("FAIL add_carry: dout=%b expected=%b", dout, 5'd16);
    else passed++;
    step(1'b0, 1'b0, 1'b0, 15, 15);
    total++;
    if (dout !== 5'd30) $display("FAIL add_max: dout=%b expected=%b", dout, 5'd30);
    else passed++;
  endtask

  task automatic test_sub_ls();
    step(1'b0, 1'b1, 1'b0, 8, 5);
    total++;
    if (dout !== 5'd3) $display("FAIL sub_ls: dout=%b expected=%b", dout, 5'd3);
    else passed++;
  endtask

  task automatic test_sub_sl();
    step(1'b0, 1'b0, 1'b1, 12, 5);
    total++;
    if (dout !== 5'b11001) $display("FAIL sub_sl_neg: dout=%b expected=%b", dout, 5'b11001);
    else passed++;
    step(1'b0, 1'b0, 1'b1, 0, 15);
    total++;
    if (dout !== 5'd15) $display("FAIL sub_sl_pos: dout=%b expected=%b", dout, 5'd15);
    else passed++;
  endtask

  task automatic test_hold();
    step(1'b0, 1'b1, 1'b0, 3, 9);
    total++;
    if (dout !== 5'b11010) $display("FAIL sub_ls_neg: dout=%b expected=%b", dout, 5'b11010);
    else passed++;
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b1, 1'b1, int'($urandom_range(0, 15)), int'($urandom_range(0, 15)));
      total++;
      if (dout !== 5'b11010) $display("FAIL hold_%0d: dout=%b expected=%b", i, dout, 5'b11010);
      else passed++;
    end
  endtask

  task automatic test_reset_priority();
    step(1'b0, 1'b0, 1'b0, 7, 6);
    step(1'b1, 1'b1, 1'b1, 2, 2);
    total++;
    if (dout !== 5'd0) $display("FAIL reset_over_hold: dout=%b expected=%b", dout, 5'd0);
    else passed++;
    step(1'b0, 1'b0, 1'b0, 9, 9);
    step(1'b1, 1'b0, 1'b0, 15, 15);
    total++;
    if (dout !== 5'd0) $display("FAIL reset_over_add: dout=%b expected=%b", dout, 5'd0);
    else passed++;
    step(1'b0, 1'b0, 1'b0, 2, 3);
    total++;
    if (dout !== 5'd5) $display("FAIL first_after_reset: dout=%b expected=%b", dout, 5'd5);
    else passed++;
  endtask

  task automatic test_back_to_back();
    bit [1:0] seq [4] = '{2'b00, 2'b10, 2'b01, 2'b11};
    for (int i = 0; i < 8; i++) begin
      bit [1:0] m;
      m = seq[i % 4];
      step(1'b0, m[1], m[0], int'($urandom_range(0, 15)), int'($urandom_range(0, 15)));
      total++;
      if (dout !== (W + 1)'(exp_dout))
        $display("FAIL back_to_back_%0d: dout=%b expected=%b", i, dout, (W + 1)'(exp_dout));
      else passed++;
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      bit rst_v;
      rst_v = ($urandom_range(0, 19) == 0);
      step(rst_v, 1'($urandom), 1'($urandom), int'($urandom_range(0, 15)),
           int'($urandom_range(0, 15)));
      total++;
      if (dout !== (W + 1)'(exp_dout))
        $display("FAIL random_%0d: dout=%b expected=%b", i, dout, (W + 1)'(exp_dout));
      else passed++;
    end
  endtask

  initial begin
    passed   = 0;
    total    = 0;
    exp_dout = 0;
    RST      = 1'b1;
    S1       = 1'b0;
    S2       = 1'b0;
    mat_L    = '0;
    mat_S    = '0;
    test_reset();
    test_add();
    test_sub_ls();
    test_sub_sl();
    test_hold();
    test_reset_priority();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
